vram_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read screen VRAM (8K x 16) between the VGA scanout

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_wbuf.sv | 40 ++++
 rtl/vram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the screen VRAM arbiter.
// Owner tags steer ram_rdata; CPU states gate the handshake.
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 16;
    localparam int SCAN_LAT    = 3;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SCAN,
        OWN_CPU
    } owner_t;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_WAIT,
        CPU_ACK,
        CPU_GAP
    } cpu_st_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer with address-compare hits.
// Ports: load/drain control, buffered entry, scan/cpu hit flags.
module vram_wbuf #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              scan_hit,
    output logic              cpu_hit
);

    // A load in the drain cycle replaces the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    assign scan_hit = valid && (scan_addr == addr);
    assign cpu_hit  = valid && (cpu_addr == addr);

endmodule

// File: rtl/vram_arbiter.sv
// Screen VRAM arbiter: scanout > CPU read > write drain.
// Ports: scan fetch, CPU bus handshake, registered VRAM port.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter bit FORWARD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Stage 0 rides with ram_addr, last stage with ram_rdata.
    localparam int DEPTH = SCAN_LAT - 1;
    localparam int LAST  = DEPTH - 1;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              scan_hit;
    logic              cpu_hit;

    logic rd_req;
    logic wr_req;
    logic rd_fwd;
    logic rd_issue;
    logic drain;
    logic wr_acc;

    cpu_st_t           st;
    owner_t            own_q  [DEPTH];
    logic              fwd_q  [DEPTH];
    logic [DATA_W-1:0] fdat_q [DEPTH];

    // Requests are only looked at in IDLE, which masks
    // the in-flight read, the ack cycle and the one after.
    assign rd_req = (st == CPU_IDLE) && cpu_req && !cpu_we;
    assign wr_req = (st == CPU_IDLE) && cpu_req && cpu_we;

    // A read hitting the buffer never goes to VRAM: it is
    // forwarded, or without forwarding it waits for the
    // drain so it cannot return stale data.
    assign rd_fwd   = rd_req && FORWARD && cpu_hit;
    assign rd_issue = rd_req && !cpu_hit && !scan_req;
    assign drain    = wb_valid && !scan_req && !rd_issue;
    assign wr_acc   = wr_req && (!wb_valid || drain);

    vram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wr_acc),
        .load_addr (cpu_addr),
        .load_data (cpu_wdata),
        .drain     (drain),
        .scan_addr (scan_addr),
        .cpu_addr  (cpu_addr),
        .valid     (wb_valid),
        .addr      (wb_addr),
        .data      (wb_data),
        .scan_hit  (scan_hit),
        .cpu_hit   (cpu_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                own_q[i]  <= OWN_NONE;
                fwd_q[i]  <= 1'b0;
                fdat_q[i] <= '0;
            end
        end else begin
            ram_we   <= 1'b0;
            own_q[0] <= OWN_NONE;
            fwd_q[0] <= 1'b0;
            unique case (1'b1)
                scan_req: begin
                    ram_addr  <= scan_addr;
                    own_q[0]  <= OWN_SCAN;
                    fwd_q[0]  <= FORWARD && scan_hit;
                    fdat_q[0] <= wb_data;
                end
                rd_issue: begin
                    ram_addr <= cpu_addr;
                    own_q[0] <= OWN_CPU;
                end
                drain: begin
                    ram_addr  <= wb_addr;
                    ram_we    <= 1'b1;
                    ram_wdata <= wb_data;
                end
                default: ;
            endcase
            for (int i = 1; i < DEPTH; i++) begin
                own_q[i]  <= own_q[i-1];
                fwd_q[i]  <= fwd_q[i-1];
                fdat_q[i] <= fdat_q[i-1];
            end
            scan_valid <= (own_q[LAST] == OWN_SCAN);
            if (own_q[LAST] == OWN_SCAN) begin
                scan_data <= fwd_q[LAST] ? fdat_q[LAST]
                                         : ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= CPU_IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            unique case (st)
                CPU_IDLE: begin
                    if (rd_fwd) begin
                        st        <= CPU_ACK;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= wb_data;
                    end else if (rd_issue) begin
                        st <= CPU_WAIT;
                    end else if (wr_acc) begin
                        st      <= CPU_ACK;
                        cpu_ack <= 1'b1;
                    end
                end
                CPU_WAIT: begin
                    if (own_q[LAST] == OWN_CPU) begin
                        st        <= CPU_ACK;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= ram_rdata;
                    end
                end
                CPU_ACK: st <= CPU_GAP;
                CPU_GAP: st <= CPU_IDLE;
                default: st <= CPU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a logical-memory model.
// Drives scan/CPU traffic, models the VRAM macro, scores all outputs.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int NW = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .FORWARD (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] lm  [NW];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sv_cnt = 0;
    int we_cnt = 0;

    int            scan_mode = 0;
    int            scan_amode = 0;
    int            scan_left = 0;
    logic          last_s = 1'b0;
    logic [AW-1:0] scan_seq = '0;
    logic [AW-1:0] scan_fix = '0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } sexp_t;
    sexp_t sq [$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // VRAM macro: synchronous read, one-cycle latency.
    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Logical memory: a write becomes visible in its ack cycle;
    // every scan must return that view three cycles later.
    initial begin
        sexp_t e;
        for (int i = 0; i < NW; i++) lm[i] = 16'(i) ^ 16'hA5A5;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sq.delete();
            end else begin
                if (cpu_ack && cpu_req && cpu_we)
                    lm[cpu_addr] = cpu_wdata;
                if (scan_valid) sv_cnt++;
                if (ram_we) we_cnt++;
                e.v = scan_req;
                e.d = lm[scan_addr];
                sq.push_back(e);
                if (sq.size() > 3) begin
                    e = sq.pop_front();
                    check("scan_valid", 32'(scan_valid), 32'(e.v));
                    if (e.v) check("scan_data", 32'(scan_data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        logic s;
        @(posedge clk);
        #1;
        cyc++;
        case (scan_mode)
            1: s = 1'b1;
            2: s = (cyc % 2 == 0);
            3: s = ($urandom_range(1, 0) == 1);
            4: s = !last_s && ($urandom_range(1, 0) == 1);
            5: s = (scan_left > 0);
            default: s = 1'b0;
        endcase
        if (scan_left > 0) scan_left--;
        last_s = s;
        scan_req = s;
        case (scan_amode)
            1: begin
                scan_addr = scan_seq;
                scan_seq++;
            end
            2: scan_addr = scan_fix;
            default: scan_addr = AW'($urandom_range(31, 0));
        endcase
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Latency counts cycles from the request cycle to the ack cycle.
    task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int exp_lat,
                          input int max_lat);
        logic [DW-1:0] exp_d;
        int lat;
        logic got;
        tick();
        exp_d = lm[a];
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < max_lat) begin
            tick();
            lat++;
            got = cpu_ack;
        end
        check(we ? "wr_done" : "rd_done", 32'(got), 1);
        if (got) begin
            if (exp_lat >= 0)
                check(we ? "wr_lat" : "rd_lat", 32'(lat), 32'(exp_lat));
            if (!we) check("rd_data", 32'(cpu_rdata), 32'(exp_d));
        end
        tick();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        if (got) check("ack_pulse", 32'(cpu_ack), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sv"}, 32'(scan_valid), 0);
        check({tag, "_sd"}, 32'(scan_data), 0);
        check({tag, "_ack"}, 32'(cpu_ack), 0);
        check({tag, "_rd"}, 32'(cpu_rdata), 0);
        check({tag, "_ra"}, 32'(ram_addr), 0);
        check({tag, "_we"}, 32'(ram_we), 0);
        check({tag, "_wd"}, 32'(ram_wdata), 0);
    endtask

    initial begin
        logic ack_seen;
        int nmis;

        ticks(3);
        check_zero("reset");
        rst_n = 1'b1;
        ticks(3);

        // Sequential scan of 0..15, one fetch per cycle.
        scan_amode = 1;
        scan_seq = '0;
        sv_cnt = 0;
        scan_mode = 1;
        ticks(16);
        scan_mode = 0;
        scan_amode = 0;
        ticks(4);
        check("scan_count", 32'(sv_cnt), 16);
        check("scan_hold", 32'(scan_data), 32'(16'h000F ^ 16'hA5A5));

        // Write posted behind continuous scan, then forwarded read.
        scan_mode = 1;
        cpu_op(1'b1, 13'h0123, 16'hBEEF, 1, 10);
        cpu_op(1'b0, 13'h0123, 16'h0000, 1, 10);
        scan_mode = 0;
        ticks(3);
        cpu_op(1'b0, 13'h0123, 16'h0000, 3, 10);
        check("vram_beef", 32'(mem[13'h0123]), 32'(16'hBEEF));

        // Reset with a read in flight.
        tick();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'h0005;
        tick();
        check("rst_pre_addr", 32'(ram_addr), 5);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_zero("rst_mid");
        ticks(3);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_ack) ack_seen = 1'b1;
        end
        check("rst_no_ack", 32'(ack_seen), 0);

        // Read starved by 20 scans, then served.
        scan_mode = 5;
        scan_left = 20;
        cpu_op(1'b0, 13'h0040, 16'h0000, 23, 40);

        // Back-to-back writes with scan every second cycle.
        we_cnt = 0;
        scan_mode = 2;
        cpu_op(1'b1, 13'h0010, 16'h0001, 1, 10);
        cpu_op(1'b1, 13'h0011, 16'h0002, 1, 10);
        scan_mode = 0;
        ticks(4);
        check("we_pulses", 32'(we_cnt), 2);
        check("vram_0010", 32'(mem[13'h0010]), 1);
        check("vram_0011", 32'(mem[13'h0011]), 2);

        // Second write waits on a full buffer until a free slot.
        scan_mode = 1;
        cpu_op(1'b1, 13'h0020, 16'h1111, 1, 10);
        scan_mode = 5;
        scan_left = 6;
        cpu_op(1'b1, 13'h0021, 16'h2222, 7, 20);
        ticks(4);
        check("vram_0020", 32'(mem[13'h0020]), 32'(16'h1111));
        check("vram_0021", 32'(mem[13'h0021]), 32'(16'h2222));

        // Scan of an undrained buffered address.
        scan_mode = 1;
        cpu_op(1'b1, 13'h1FFF, 16'h8001, 1, 10);
        scan_fix = 13'h1FFF;
        scan_amode = 2;
        ticks(4);
        check("coh_valid", 32'(scan_valid), 1);
        check("coh_data", 32'(scan_data), 32'(16'h8001));
        check("coh_undrained", 32'(mem[13'h1FFF]), 32'(16'h1FFF ^ 16'hA5A5));
        scan_mode = 0;
        scan_amode = 0;
        ticks(5);
        check("vram_1fff", 32'(mem[13'h1FFF]), 32'(16'h8001));

        // Random traffic, scans at most every other cycle.
        scan_mode = 4;
        for (int n = 0; n < 150; n++) begin
            cpu_op(1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)),
                   16'($urandom), -1, 6);
            ticks($urandom_range(2, 0));
        end

        // Random traffic, unconstrained scans.
        scan_mode = 3;
        for (int n = 0; n < 150; n++) begin
            cpu_op(1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)),
                   16'($urandom), -1, 60);
            ticks($urandom_range(2, 0));
        end

        scan_mode = 0;
        ticks(6);
        nmis = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== lm[i]) nmis++;
        check("vram_final", 32'(nmis), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
